exu_div: RTL and testbench
==========================

# exu_div

Multi-cycle integer divide/remainder unit inside the execute stage. It consumes the divide-class ALU operations emitted by the decoder (ALUop 17–24) with both operands, runs a radix-2 restoring division, and returns the quotient or remainder for write-back. While it computes, it raises a stall request into the pipeline stall controller, so the instruction stays in EX until the result is valid.

## Interface
- XLEN, 64: operand/result width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start_i  in  1  divide-class op present in EX; sampled only in IDLE.
- op_i  in  `ALUOP_WIDTH  ALUop code:
  - 17 divw, 18 remw, 19 divuw, 20 remuw
  - 21 divu, 22 remu, 23 div, 24 rem
  - any other value with start_i high is ignored.
- a_i  in  XLEN  dividend (rs1 value).
- b_i  in  XLEN  divisor (rs2 value).
- flush_i  in  1  pipeline flush; aborts any operation.
- busy_o  out  1  high in CALC and DONE.
- stallreq_o  out  1  stall request to the stall controller.
- valid_o  out  1  one-cycle result-valid pulse.
- result_o  out  XLEN  quotient or remainder; held until the next accepted start.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - On start_i with a legal op_i, latch the op and the operands.
  - If the case is special (below), go to DONE with the final result; otherwise go to CALC.
- W ops (17–20): operate on a_i[31:0] and b_i[31:0]. Signed W ops sign-extend the 32-bit inputs; unsigned W ops zero-extend them. The iteration count is 32. The 32-bit result is sign-extended to 64 bits for all four W ops, including divuw and remuw.
- Full ops (21–24): iteration count is 64.
- Signed ops (div, rem, divw, remw):
  - Divide absolute values.
  - Negate the quotient when the operand signs differ.
  - The remainder takes the sign of the dividend.
- Iterations:
  - Each CALC cycle performs one shift-subtract step: shift remainder left with the next dividend bit, then trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set 0.
  - An iteration counter loads the iteration count on entry to CALC and decrements every cycle.
  - The transition to DONE occurs on the last iteration (counter = 1).
- Special cases (RISC-V semantics), resolved in IDLE with no iterations:
  - Divisor = 0: quotient = all ones (-1), remainder = dividend. For W ops, these are taken on the 32-bit value and then sign-extended.
  - Signed overflow (dividend = most-negative value, divisor = -1, at the op width): quotient = dividend, remainder = 0.
- DONE:
  - valid_o = 1; result_o holds the selected result.
  - start_i is ignored, because the same instruction is still in EX.
  - Next state is always IDLE.
- Flush: flush_i in any state forces IDLE on the next edge. valid_o is suppressed in that cycle and result_o is unchanged. Flush has priority over start_i and over the transition to DONE.
- Reset (asynchronous, may occur mid-operation): state = IDLE, counter = 0, latched operands = 0, result_o = 0, valid_o = 0, busy_o = 0, stallreq_o = 0.

## Timing
- stallreq_o:
  - Combinational: high when (IDLE and start_i and legal op_i) or CALC.
  - Low in DONE, so the pipeline advances at the end of the DONE cycle.
  - Low whenever flush_i is high.
- Latency, with start sampled in cycle T:
  - Full op: CALC T+1..T+64, DONE/valid_o at T+65.
  - W op: CALC T+1..T+32, DONE at T+33.
  - Special case: DONE at T+1.
- Back-to-back: a new start is accepted at the earliest in the cycle after DONE (IDLE). There is no overlap between operations.
- result_o updates on the edge that enters DONE and is stable for the whole DONE cycle and afterwards.
- valid_o is asserted for exactly one cycle per completed (non-flushed) operation.

## Test plan
- div, a = 100, b = -7, start at T:
  - stallreq_o high T..T+64.
  - valid_o at T+65, result_o = 0xFFFF_FFFF_FFFF_FFF2 (-14).
  - Repeat with rem: result_o = 2.
- divu, a = 5, b = 0: valid_o at T+1, result_o = 0xFFFF_FFFF_FFFF_FFFF. remu with the same operands: result_o = 5.
- Signed overflow:
  - div, a = 0x8000_0000_0000_0000, b = -1: result_o = 0x8000_0000_0000_0000 at T+1.
  - divw, a = 0x0000_0000_8000_0000, b = 0xFFFF_FFFF_FFFF_FFFF: result_o = 0xFFFF_FFFF_8000_0000.
- W ops, 32 iterations:
  - remuw, a = 0x1_0000_0007, b = 3: valid_o at T+33, result_o = 1.
  - divuw, a = 0xFFFF_FFFE, b = 1: result_o = 0xFFFF_FFFF_FFFF_FFFE (sign-extended).
- Flush: flush_i at T+10 during a full div.
  - IDLE at T+11; no valid_o ever; stallreq_o low from T+10.
  - A new divu started at T+11 completes at T+76.
- Async reset: assert rst mid-CALC, between clock edges. All outputs are 0 immediately. After release, a start is accepted and the result is correct (50 divu 7 → 7).

Source files
------------

// File: rtl/exu_div.sv
// exu_div: radix-2 restoring divide/remainder unit for the execute stage.
// Stalls the pipeline while iterating and pulses valid_o for one cycle on completion.
module exu_div #(
    parameter int XLEN        = 64,
    parameter int ALUOP_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [ALUOP_WIDTH-1:0] op_i,
    input  logic [XLEN-1:0]        a_i,
    input  logic [XLEN-1:0]        b_i,
    input  logic                   flush_i,
    output logic                   busy_o,
    output logic                   stallreq_o,
    output logic                   valid_o,
    output logic [XLEN-1:0]        result_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

    state_e          state_q;
    logic [6:0]      cnt_q;
    logic            is_w_q, rem_op_q, neg_q_q, neg_r_q;
    logic [XLEN-1:0] dvs_q, quo_q, rem_q, result_q;

    logic            legal, op_w, op_sg, op_rem;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, dvd0, a_fit, spec_res;
    logic            a_neg, b_neg, div_zero, ovf, special;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] rem_d, quo_d, q_fin, r_fin, sel, res_fin;

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
        return {{(XLEN-32){x[31]}}, x[31:0]};
    endfunction

    always_comb begin
        legal  = 1'b0;
        op_w   = 1'b0;
        op_sg  = 1'b0;
        op_rem = 1'b0;
        unique case (op_i)
            ALUOP_WIDTH'(17): begin legal = 1'b1; op_w = 1'b1; op_sg = 1'b1; end
            ALUOP_WIDTH'(18): begin legal = 1'b1; op_w = 1'b1; op_sg = 1'b1; op_rem = 1'b1; end
            ALUOP_WIDTH'(19): begin legal = 1'b1; op_w = 1'b1; end
            ALUOP_WIDTH'(20): begin legal = 1'b1; op_w = 1'b1; op_rem = 1'b1; end
            ALUOP_WIDTH'(21): begin legal = 1'b1; end
            ALUOP_WIDTH'(22): begin legal = 1'b1; op_rem = 1'b1; end
            ALUOP_WIDTH'(23): begin legal = 1'b1; op_sg = 1'b1; end
            ALUOP_WIDTH'(24): begin legal = 1'b1; op_sg = 1'b1; op_rem = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        a_ext = a_i;
        b_ext = b_i;
        if (op_w) begin
            a_ext = op_sg ? sext_w(a_i) : {{(XLEN-32){1'b0}}, a_i[31:0]};
            b_ext = op_sg ? sext_w(b_i) : {{(XLEN-32){1'b0}}, b_i[31:0]};
        end
    end

    assign a_neg    = op_sg & a_ext[XLEN-1];
    assign b_neg    = op_sg & b_ext[XLEN-1];
    assign a_mag    = a_neg ? -a_ext : a_ext;
    assign b_mag    = b_neg ? -b_ext : b_ext;
    // W dividends sit in the upper half so 32 MSB-first shifts consume them exactly
    assign dvd0     = op_w ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
    assign div_zero = (b_ext == '0);
    assign ovf      = op_sg && (b_ext == '1) && (a_ext == (op_w ? MIN_W : MIN_D));
    assign special  = div_zero | ovf;
    assign a_fit    = op_w ? sext_w(a_ext) : a_ext;

    always_comb begin
        spec_res = '0;
        if (div_zero) spec_res = op_rem ? a_fit : '1;
        else          spec_res = op_rem ? '0 : a_fit;
    end

    assign rem_sh  = {rem_q, quo_q[XLEN-1]};
    assign diff    = rem_sh - {1'b0, dvs_q};
    assign rem_d   = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_d   = {quo_q[XLEN-2:0], ~diff[XLEN]};
    assign q_fin   = neg_q_q ? -quo_d : quo_d;
    assign r_fin   = neg_r_q ? -rem_d : rem_d;
    assign sel     = rem_op_q ? r_fin : q_fin;
    assign res_fin = is_w_q ? sext_w(sel) : sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_w_q   <= 1'b0;
            rem_op_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dvs_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i && legal && !flush_i) begin
                        is_w_q   <= op_w;
                        rem_op_q <= op_rem;
                        neg_q_q  <= a_neg ^ b_neg;
                        neg_r_q  <= a_neg;
                        dvs_q    <= b_mag;
                        quo_q    <= dvd0;
                        rem_q    <= '0;
                        if (special) begin
                            result_q <= spec_res;
                            state_q  <= DONE;
                        end else begin
                            cnt_q   <= op_w ? 7'd32 : 7'd64;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q - 7'd1;
                        if (cnt_q == 7'd1) begin
                            result_q <= res_fin;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign valid_o    = (state_q == DONE) && !flush_i;
    assign stallreq_o = !flush_i &&
                        (((state_q == IDLE) && start_i && legal) || (state_q == CALC));
    assign result_o   = result_q;

endmodule

// File: tb/tb_exu_div.sv
// tb_exu_div: directed and randomized checks of exu_div against an
// arithmetic reference model (RISC-V divide semantics, latency rules).
module tb_exu_div;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [4:0]  op_i = '0;
    logic [63:0] a_i = '0;
    logic [63:0] b_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o, stallreq_o, valid_o;
    logic [63:0] result_o;

    int n_chk = 0;
    int n_err = 0;
    int n_valid = 0;
    int exp_valid = 0;

    exu_div dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .busy_o(busy_o),
        .stallreq_o(stallreq_o), .valid_o(valid_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (valid_o) n_valid++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    function automatic logic [63:0] ref_res(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        bit w, sg, rm, ov;
        logic [63:0] ax, bx, q, r;
        longint sa, sb;
        w  = (op <= 5'd20);
        sg = op inside {5'd17, 5'd18, 5'd23, 5'd24};
        rm = op inside {5'd18, 5'd20, 5'd22, 5'd24};
        ax = w ? (sg ? sx(a[31:0]) : {32'b0, a[31:0]}) : a;
        bx = w ? (sg ? sx(b[31:0]) : {32'b0, b[31:0]}) : b;
        ov = w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
               : (a == 64'h8000_0000_0000_0000 && b == '1);
        sa = $signed(ax);
        sb = $signed(bx);
        if (bx == 0) begin
            q = '1;
            r = ax;
        end else if (sg && ov) begin
            q = ax;
            r = '0;
        end else if (sg) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = ax / bx;
            r = ax % bx;
        end
        return w ? sx(rm ? r[31:0] : q[31:0]) : (rm ? r : q);
    endfunction

    function automatic int ref_lat(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        bit w, sg, zero, ov;
        w    = (op <= 5'd20);
        sg   = op inside {5'd17, 5'd18, 5'd23, 5'd24};
        zero = w ? (b[31:0] == 0) : (b == 0);
        ov   = sg && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                        : (a == 64'h8000_0000_0000_0000 && b == '1));
        if (zero || ov) return 1;
        return w ? 33 : 65;
    endfunction

    // Called just after a negedge; returns just after a negedge in IDLE.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int lat);
        int n;
        bit bad;
        start_i = 1'b1;
        op_i = op;
        a_i = a;
        b_i = b;
        #1;
        chk({tag, "_stall_t"}, 64'(stallreq_o), 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        n = 1;
        bad = 0;
        while (!valid_o && n < 100) begin
            if (!stallreq_o || !busy_o) bad = 1;
            @(negedge clk);
            n++;
        end
        exp_valid++;
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_stall_calc"}, 64'(bad), 64'd0);
        chk({tag, "_res"}, result_o, exp);
        chk({tag, "_stall_done"}, 64'(stallreq_o), 64'd0);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(valid_o), 64'd0);
        chk({tag, "_hold"}, result_o, exp);
        chk({tag, "_idle"}, 64'(busy_o), 64'd0);
    endtask

    task automatic run_ref(input string tag, input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        run_op(tag, op, a, b, ref_res(op, a, b), ref_lat(op, a, b));
    endtask

    function automatic logic [63:0] rnd64();
        unique case ($urandom_range(0, 6))
            0: return '0;
            1: return '1;
            2: return 64'($urandom_range(1, 20));
            3: return 64'h8000_0000_0000_0000;
            4: return {$urandom, 32'h8000_0000};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_stall", 64'(stallreq_o), 64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_res", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("div", 5'd23, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
        run_op("rem", 5'd24, 64'd100, -64'sd7, 64'd2, 65);
        run_op("divu0", 5'd21, 64'd5, 64'd0, '1, 1);
        run_op("remu0", 5'd22, 64'd5, 64'd0, 64'd5, 1);
        run_op("div_ovf", 5'd23, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        run_op("divw_ovf", 5'd17, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("remuw", 5'd20, 64'h1_0000_0007, 64'd3, 64'd1, 33);
        run_op("divuw", 5'd19, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33);

        // illegal op is ignored
        start_i = 1'b1;
        op_i = 5'd5;
        #1;
        chk("ill_stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        chk("ill_busy", 64'(busy_o), 64'd0);

        // flush mid-CALC at T+10
        start_i = 1'b1;
        op_i = 5'd23;
        a_i = 64'd100;
        b_i = -64'sd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        #1;
        chk("fl_stall", 64'(stallreq_o), 64'd0);
        chk("fl_valid", 64'(valid_o), 64'd0);
        @(negedge clk);
        flush_i = 1'b0;
        chk("fl_idle", 64'(busy_o), 64'd0);
        run_op("fl_divu", 5'd21, 64'd1000, 64'd7, 64'd142, 65);

        // async reset between edges during CALC
        start_i = 1'b1;
        op_i = 5'd21;
        a_i = 64'd12345;
        b_i = 64'd11;
        @(negedge clk);
        start_i = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_busy", 64'(busy_o), 64'd0);
        chk("ar_stall", 64'(stallreq_o), 64'd0);
        chk("ar_valid", 64'(valid_o), 64'd0);
        chk("ar_res", result_o, 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        run_op("ar_divu", 5'd21, 64'd50, 64'd7, 64'd7, 65);

        for (int i = 0; i < 40; i++) begin
            logic [4:0] op;
            op = 5'($urandom_range(17, 24));
            run_ref($sformatf("rnd%0d_op%0d", i, op), op, rnd64(), rnd64());
        end

        chk("valid_count", 64'(n_valid), 64'(exp_valid));
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
